// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared constants, state encoding and target check for the PC stage
package pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IMM_W            = 16;
    localparam int          JIDX_W           = 26;

    localparam logic [1:0]  ST_RUN   = 2'd0;
    localparam logic [1:0]  ST_PEND  = 2'd1;
    localparam logic [1:0]  ST_FAULT = 2'd2;

    // Word-aligned and inside [base, last]; compares are unsigned.
    function automatic logic target_ok(
        input logic [31:0] target,
        input logic [31:0] base,
        input logic [31:0] last
    );
        return (target[1:0] == 2'b00) && (target >= base) && (target <= last);
    endfunction

endpackage

// File: rtl/pc_unit_npc_calc.sv
// rtl/pc_unit_npc_calc.sv - combinational next-PC selection and validity check
module npc_calc
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] LAST_PC  = RESET_PC_DEFAULT + 32'h0000_0FFC
) (
    input  logic [31:0]       i_pc,
    input  logic              i_br_taken,
    input  logic [IMM_W-1:0]  i_br_off,
    input  logic              i_j_en,
    input  logic [JIDX_W-1:0] i_j_index,
    input  logic              i_jr_en,
    input  logic [31:0]       i_jr_target,
    output logic [31:0]       o_pc_plus4,
    output logic [31:0]       o_target,
    output logic              o_redirect,
    output logic              o_valid
);

    logic [31:0] w_br_disp;

    assign o_pc_plus4 = i_pc + 32'd4;
    assign w_br_disp  = {{(32-IMM_W-2){i_br_off[IMM_W-1]}}, i_br_off, 2'b00};
    assign o_redirect = i_jr_en | i_j_en | i_br_taken;

    always_comb begin
        o_target = o_pc_plus4;
        if (i_jr_en) begin
            o_target = i_jr_target;
        end else if (i_j_en) begin
            o_target = {o_pc_plus4[31:28], i_j_index, 2'b00};
        end else if (i_br_taken) begin
            o_target = o_pc_plus4 + w_br_disp;
        end
    end

    // Sequential fall-through past the last word is caught here too.
    assign o_valid = target_ok(o_target, RESET_PC, LAST_PC);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with stall-pending redirect and sticky fault
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_br_taken,
    input  logic [IMM_W-1:0]  i_br_off,
    input  logic              i_j_en,
    input  logic [JIDX_W-1:0] i_j_index,
    input  logic              i_jr_en,
    input  logic [31:0]       i_jr_target,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    output logic              o_fault,
    output logic [31:0]       o_fault_addr
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(IMEM_WORDS * 4) - 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic [31:0] r_fault_addr;

    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_valid;
    logic        w_pend_ok;

    npc_calc #(
        .RESET_PC (RESET_PC),
        .LAST_PC  (LAST_PC)
    ) u_npc_calc (
        .i_pc        (r_pc),
        .i_br_taken  (i_br_taken),
        .i_br_off    (i_br_off),
        .i_j_en      (i_j_en),
        .i_j_index   (i_j_index),
        .i_jr_en     (i_jr_en),
        .i_jr_target (i_jr_target),
        .o_pc_plus4  (o_pc_plus4),
        .o_target    (w_target),
        .o_redirect  (w_redirect),
        .o_valid     (w_valid)
    );

    assign w_pend_ok = target_ok(r_pend, RESET_PC, LAST_PC);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pend       <= 32'd0;
            r_fault_addr <= 32'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!i_stall) begin
                        if (w_valid) begin
                            r_pc <= w_target;
                        end else begin
                            r_fault_addr <= w_target;
                            r_state      <= ST_FAULT;
                        end
                    end else if (w_redirect) begin
                        r_pend  <= w_target;
                        r_state <= ST_PEND;
                    end
                end
                // First captured redirect wins; live redirect inputs are ignored here.
                ST_PEND: begin
                    if (!i_stall) begin
                        if (w_pend_ok) begin
                            r_pc    <= r_pend;
                            r_state <= ST_RUN;
                        end else begin
                            r_fault_addr <= r_pend;
                            r_state      <= ST_FAULT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign o_pc         = r_pc;
    assign o_fault      = (r_state == ST_FAULT);
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_off;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .RESET_PC   (32'h0000_3000),
        .IMEM_WORDS (1024)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_br_taken   (br_taken),
        .i_br_off     (br_off),
        .i_j_en       (j_en),
        .i_j_index    (j_index),
        .i_jr_en      (jr_en),
        .i_jr_target  (jr_target),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .o_fault      (fault),
        .o_fault_addr (fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_off    = 16'h0;
        j_en      = 1'b0;
        j_index   = 26'h0;
        jr_en     = 1'b0;
        jr_target = 32'h0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] seq_exp [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};

    initial begin
        clear_in();
        rst_n = 1'b0;
        advance(2);
        check("rst_pc", pc, 32'h3000);
        check("rst_pc_plus4", pc_plus4, 32'h3004);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_addr", fault_addr, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("seq_pc", pc, seq_exp[i]);
            check("seq_pc_plus4", pc_plus4, seq_exp[i] + 32'd4);
            check("seq_fault", {31'd0, fault}, 32'd0);
        end

        // Backward branch then jump-over-branch priority.
        do_reset();
        advance(2);
        check("bb_start", pc, 32'h3008);
        br_taken = 1'b1; br_off = 16'hFFFE;
        step();
        check("bb_pc", pc, 32'h3004);
        clear_in();
        step();
        check("bb_back", pc, 32'h3008);
        br_taken = 1'b1; br_off = 16'hFFFE; j_en = 1'b1; j_index = 26'h0000C10;
        step();
        check("j_prio_pc", pc, 32'h3040);
        clear_in();

        // jr to a misaligned address faults and freezes.
        do_reset();
        advance(4);
        check("jr_start", pc, 32'h3010);
        jr_en = 1'b1; jr_target = 32'h3002;
        step();
        check("jr_pc_hold", pc, 32'h3010);
        check("jr_fault", {31'd0, fault}, 32'd1);
        check("jr_fault_addr", fault_addr, 32'h3002);
        for (int i = 0; i < 5; i++) begin
            stall = i[0]; br_taken = 1'b1; br_off = 16'h0004;
            j_en = i[1]; j_index = 26'h0000C04; jr_en = i[2]; jr_target = 32'h3100;
            step();
            check("flt_pc", pc, 32'h3010);
            check("flt_fault", {31'd0, fault}, 32'd1);
            check("flt_addr", fault_addr, 32'h3002);
        end
        do_reset();
        check("flt_rst_pc", pc, 32'h3000);
        check("flt_rst_fault", {31'd0, fault}, 32'd0);
        check("flt_rst_addr", fault_addr, 32'h0);

        // Out-of-range jr below base also faults.
        jr_en = 1'b1; jr_target = 32'h2FFC;
        step();
        check("low_fault", {31'd0, fault}, 32'd1);
        check("low_addr", fault_addr, 32'h2FFC);
        check("low_pc", pc, 32'h3000);

        // Stalled jump is captured; later branch under stall and at release is ignored.
        do_reset();
        step();
        check("st_start", pc, 32'h3004);
        stall = 1'b1; j_en = 1'b1; j_index = 26'h0000C08;
        step();
        check("st_cap_pc", pc, 32'h3004);
        j_en = 1'b0; br_taken = 1'b1; br_off = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold_pc", pc, 32'h3004);
        end
        stall = 1'b0;
        step();
        check("st_release_pc", pc, 32'h3020);
        check("st_release_fault", {31'd0, fault}, 32'd0);
        clear_in();

        // Reset while a redirect is pending discards it.
        stall = 1'b1; br_taken = 1'b1; br_off = 16'h0004;
        step();
        check("mp_cap_pc", pc, 32'h3020);
        rst_n = 1'b0;
        step();
        check("mp_rst_pc", pc, 32'h3000);
        rst_n = 1'b1; br_taken = 1'b0; br_off = 16'h0;
        step();
        check("mp_stall_pc", pc, 32'h3000);
        stall = 1'b0;
        step();
        check("mp_release_pc", pc, 32'h3004);

        // Sequential run to the last word, then fall off the end.
        do_reset();
        advance(1023);
        check("ub_last_pc", pc, 32'h3FFC);
        check("ub_last_fault", {31'd0, fault}, 32'd0);
        step();
        check("ub_pc_hold", pc, 32'h3FFC);
        check("ub_fault", {31'd0, fault}, 32'd1);
        check("ub_fault_addr", fault_addr, 32'h4000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
